fir_serial_ctrl: RTL and testbench
==================================

Name: fir_serial_ctrl

Overview:
Time-multiplexed FIR engine controller. It accepts one sample per en pulse and stores it in a circular delay line. An FSM then sequences a single shared multiplier/accumulator across all TAPS coefficients and emits one filtered result with a valid pulse. Coefficients are held in an internal register file that the host configures; this replaces the fully parallel FIR wherever the system clock is at least TAPS+2 times the sample rate.

Parameters:
TAPS, 16, number of taps; power of two, 4..64
DW, 12, input sample width, signed two's complement
CW, 12, coefficient width, signed two's complement
OW, 29, output width; must be >= DW+CW+log2(TAPS); result is sign-extended to OW

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  single-cycle sample strobe; xin is valid in the same cycle
xin  in  DW  input sample, signed
coef_we  in  1  coefficient write strobe
coef_addr  in  log2(TAPS)  coefficient index k
coef_data  in  CW  coefficient value h[k], signed
ovr_clr  in  1  clears the overrun flag
busy  out  1  high while a sample is being processed
coef_rdy  out  1  equals ~busy; coefficient writes are accepted only when high
valid  out  1  one-cycle pulse when yout updates
yout  out  OW  filter output y[n] = sum over k=0..TAPS-1 of h[k]*x[n-k], signed
overrun  out  1  sticky flag: a sample was dropped

Behaviour:
- Reset (rstn=0, async): state IDLE; delay line all zero; coefficients all zero; write pointer 0; accumulator 0; busy=0, valid=0, yout=0, overrun=0, coef_rdy=1. Reset asserted mid-computation aborts it, and no valid pulse is issued for that sample.
- FSM states: IDLE, MAC, DRAIN, OUT.
- IDLE: en=1 at edge E0 writes xin to delay[wr_ptr], latches base=wr_ptr, increments wr_ptr (wrapping TAPS-1 to 0), clears the accumulator and tap counter k, sets busy=1, and moves to MAC.
- MAC: on each edge, product register <= delay[(base-k) mod TAPS] * h[k] (full DW+CW signed product). The accumulator adds the previous product from the second MAC edge onward. k increments each edge. When k=TAPS-1 the FSM moves to DRAIN. MAC lasts exactly TAPS cycles.
- DRAIN: the accumulator adds the final product, then the FSM moves to OUT.
- OUT: yout <= accumulator sign-extended to OW; valid=1 for this one cycle; busy=0 at the following edge; the FSM returns to IDLE.
- Latency: valid is high in the cycle beginning at edge E0+TAPS+2. The minimum en spacing is TAPS+2 cycles. An en arriving on the edge immediately after OUT is accepted.
- Accumulator width is DW+CW+log2(TAPS). Overflow cannot occur. No rounding or truncation is applied.
- Overrun: en=1 while busy=1 drops the sample (delay line and wr_ptr unchanged) and sets overrun=1. If ovr_clr and a dropped en occur in the same cycle, set wins. ovr_clr alone clears overrun on the next edge.
- Coefficient write: coef_we=1 with busy=0 writes h[coef_addr] on the edge. A write attempted with busy=1 is ignored, with no flag. If coef_we and en occur in the same IDLE cycle, the write is applied and the new coefficient is used for that sample.
- yout holds its last value between valid pulses.

Test Plan:
- Reset, then write h[0]=1 (others 0). Send en with xin=0x123 -> 18 cycles later valid=1 and yout=0x123; busy is high for those 18 cycles.
- Write all h[k]=1. Send 16 samples of xin=1, spaced 20 cycles apart -> successive yout values 1,2,...,16; a 17th sample gives 16 (buffer wrap).
- Write h[3]=0xFFF (-1). Send xin=0x800 (-2048) followed by three samples of 0 -> fourth output yout=+2048; earlier outputs are 0.
- Write all h=0x800 and send 16 samples of 0x800 -> final yout=67108864 (2^26), exact with no wrap.
- Send en, then a second en 5 cycles later -> overrun=1 and the second sample is absent from later outputs. Assert ovr_clr -> overrun=0. Assert ovr_clr together with another dropped en -> overrun stays 1.
- Pull rstn low 6 cycles after en -> no valid pulse, yout=0, and the delay line is cleared. Attempt coef_we while busy -> h is unchanged, verified by an impulse response.

Source files
------------

// File: rtl/fir_serial_ctrl.sv
// Time-multiplexed FIR controller: one shared multiplier/accumulator is stepped
// across all taps for every accepted sample, held in a circular delay line.
module fir_serial_ctrl #(
   parameter int TAPS = 16,
   parameter int DW   = 12,
   parameter int CW   = 12,
   parameter int OW   = 29
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     en,
   input  logic [DW-1:0]            xin,
   input  logic                     coef_we,
   input  logic [$clog2(TAPS)-1:0]  coef_addr,
   input  logic [CW-1:0]            coef_data,
   input  logic                     ovr_clr,
   output logic                     busy,
   output logic                     coef_rdy,
   output logic                     valid,
   output logic [OW-1:0]            yout,
   output logic                     overrun
);

   localparam int AW   = $clog2(TAPS);
   localparam int PW   = DW + CW;
   localparam int ACCW = PW + AW;
   localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DRAIN, S_OUT} state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic signed [DW-1:0]    r_delay [TAPS];
   logic signed [CW-1:0]    r_coef  [TAPS];
   logic [AW-1:0]           r_wr_ptr;
   logic [AW-1:0]           r_base;
   logic [AW-1:0]           r_k;
   logic [AW-1:0]           w_rd_idx;
   logic signed [PW-1:0]    w_prod;
   logic signed [PW-1:0]    r_prod;
   logic signed [ACCW-1:0]  r_acc;
   logic [OW-1:0]           r_yout;
   logic                    r_valid;
   logic                    r_overrun;
   logic                    w_busy;

   // Newest sample sits at base; tap k reaches k samples back, wrapping mod TAPS.
   assign w_rd_idx = r_base - r_k;
   assign w_prod   = PW'(r_delay[w_rd_idx]) * PW'(r_coef[r_k]);
   assign w_busy   = (r_state != S_IDLE);

   assign busy     = w_busy;
   assign coef_rdy = ~w_busy;
   assign valid    = r_valid;
   assign yout     = r_yout;
   assign overrun  = r_overrun;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (en) w_next = S_MAC;
         S_MAC:   if (r_k == K_LAST) w_next = S_DRAIN;
         S_DRAIN: w_next = S_OUT;
         S_OUT:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < TAPS; i++) begin
            r_delay[i] <= '0;
            r_coef[i]  <= '0;
         end
         r_wr_ptr  <= '0;
         r_base    <= '0;
         r_k       <= '0;
         r_prod    <= '0;
         r_acc     <= '0;
         r_yout    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_valid <= 1'b0;

         // Written before the MAC phase reads it, so a same-cycle write is used.
         if (coef_we && !w_busy) begin
            r_coef[coef_addr] <= coef_data;
         end

         if (en && w_busy) begin
            r_overrun <= 1'b1;
         end else if (ovr_clr) begin
            r_overrun <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (en) begin
                  r_delay[r_wr_ptr] <= xin;
                  r_base            <= r_wr_ptr;
                  r_wr_ptr          <= r_wr_ptr + AW'(1);
                  r_acc             <= '0;
                  r_k               <= '0;
               end
            end
            S_MAC: begin
               r_prod <= w_prod;
               // Product register is one stage behind; nothing to add on the first edge.
               if (r_k != '0) begin
                  r_acc <= r_acc + ACCW'(r_prod);
               end
               r_k <= r_k + AW'(1);
            end
            S_DRAIN: begin
               r_acc <= r_acc + ACCW'(r_prod);
            end
            S_OUT: begin
               r_yout  <= OW'(r_acc);
               r_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_serial_ctrl.sv
// Self-checking bench for fir_serial_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_fir_serial_ctrl;

   localparam int TAPS = 16;
   localparam int DW   = 12;
   localparam int CW   = 12;
   localparam int OW   = 29;
   localparam int LAT  = TAPS + 2;

   logic            clk = 1'b0;
   logic            rstn;
   logic            en;
   logic [DW-1:0]   xin;
   logic            coef_we;
   logic [3:0]      coef_addr;
   logic [CW-1:0]   coef_data;
   logic            ovr_clr;
   logic            busy;
   logic            coef_rdy;
   logic            valid;
   logic [OW-1:0]   yout;
   logic            overrun;

   int n_checks = 0;
   int n_errors = 0;

   fir_serial_ctrl #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .en        (en),
      .xin       (xin),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .ovr_clr   (ovr_clr),
      .busy      (busy),
      .coef_rdy  (coef_rdy),
      .valid     (valid),
      .yout      (yout),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: history of accepted samples (newest first), coefficient
   // array, and the time at which the pending result must appear.
   int             m_h [TAPS];
   int             m_hist [$];
   bit             m_busy, m_valid, m_ovr, m_old_busy;
   logic [OW-1:0]  m_yout;
   longint         m_pend, m_sum;
   int             m_cyc, m_done;

   always @(posedge clk) begin
      if (!rstn) begin
         foreach (m_h[i]) m_h[i] = 0;
         m_hist.delete();
         m_busy  = 0;
         m_valid = 0;
         m_ovr   = 0;
         m_yout  = '0;
         m_pend  = 0;
         m_cyc   = 0;
         m_done  = -1;
      end else begin
         m_cyc++;
         m_old_busy = m_busy;
         m_valid    = 0;
         if (en && m_old_busy) m_ovr = 1;
         else if (ovr_clr)     m_ovr = 0;
         if (coef_we && !m_old_busy) m_h[coef_addr] = int'($signed(coef_data));
         if (en && !m_old_busy) begin
            m_hist.push_front(int'($signed(xin)));
            if (m_hist.size() > TAPS) void'(m_hist.pop_back());
            m_sum = 0;
            for (int k = 0; k < m_hist.size(); k++) m_sum += longint'(m_h[k]) * m_hist[k];
            m_pend = m_sum;
            m_busy = 1;
            m_done = m_cyc + LAT;
         end else if (m_old_busy && m_cyc == m_done) begin
            m_valid = 1;
            m_yout  = m_pend[OW-1:0];
            m_busy  = 0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         check("valid",    valid,    m_valid);
         check("busy",     busy,     m_busy);
         check("coef_rdy", coef_rdy, !m_busy);
         check("overrun",  overrun,  m_ovr);
         check("yout",     yout,     m_yout);
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic wr_coef(input int a, input logic [CW-1:0] d);
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = a[3:0];
      coef_data = d;
      @(negedge clk);
      coef_we   = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] x);
      @(negedge clk);
      en  = 1'b1;
      xin = x;
      @(negedge clk);
      en  = 1'b0;
   endtask

   task automatic wait_valid(input string nm, output int lat, output logic [OW-1:0] y);
      lat = -1;
      y   = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            lat = i;
            y   = yout;
            break;
         end
      end
      if (lat < 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s_timeout: got no valid pulse expected one within 40 cycles", nm);
      end
   endtask

   initial begin
      int            lat;
      int            nvalid;
      logic [OW-1:0] y;

      rstn = 1'b0; en = 1'b0; xin = '0; coef_we = 1'b0;
      coef_addr = '0; coef_data = '0; ovr_clr = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_yout", yout, 0);
      check("rst_overrun", overrun, 0);
      check("rst_coef_rdy", coef_rdy, 1);

      // Impulse coefficient: latency and pass-through value
      wr_coef(0, 12'd1);
      send(12'h123);
      wait_valid("impulse", lat, y);
      check("impulse_latency", lat, LAT);
      check("impulse_yout", y, 32'h123);

      // Moving sum of ones, including wrap of the delay line
      do_reset();
      for (int k = 0; k < TAPS; k++) wr_coef(k, 12'd1);
      for (int n = 1; n <= TAPS + 1; n++) begin
         send(12'd1);
         wait_valid("ramp", lat, y);
         if (n == 1)         check("ramp_first", y, 1);
         else if (n == 8)    check("ramp_mid", y, 8);
         else if (n == TAPS) check("ramp_full", y, 16);
         else if (n > TAPS)  check("ramp_wrap", y, 16);
      end

      // Negative coefficient times negative sample at tap 3
      do_reset();
      wr_coef(3, 12'hFFF);
      send(12'h800);
      wait_valid("neg0", lat, y);
      check("neg_out0", y, 0);
      for (int n = 1; n <= 3; n++) begin
         send(12'h000);
         wait_valid("negn", lat, y);
         if (n < 3) check("neg_early", y, 0);
         else       check("neg_out3", y, 2048);
      end

      // Extreme magnitudes: full-scale negative everywhere
      do_reset();
      for (int k = 0; k < TAPS; k++) wr_coef(k, 12'h800);
      for (int n = 0; n < TAPS; n++) begin
         send(12'h800);
         wait_valid("max", lat, y);
      end
      check("max_yout", y, 67108864);

      // Overrun: dropped sample, clear, and set-wins-over-clear
      do_reset();
      wr_coef(0, 12'd1);
      send(12'd5);
      repeat (4) @(negedge clk);
      en = 1'b1; xin = 12'd7;
      @(negedge clk);
      en = 1'b0;
      check("ovr_set", overrun, 1);
      wait_valid("ovr_a", lat, y);
      check("ovr_first", y, 5);
      wr_coef(1, 12'd1);
      send(12'd9);
      wait_valid("ovr_b", lat, y);
      check("ovr_dropped_absent", y, 14);
      @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      check("ovr_clear", overrun, 0);
      send(12'd2);
      en = 1'b1; ovr_clr = 1'b1; xin = 12'd4;
      @(negedge clk);
      en = 1'b0; ovr_clr = 1'b0;
      check("ovr_set_wins", overrun, 1);
      wait_valid("ovr_c", lat, y);
      check("ovr_after", y, 11);

      // Reset mid-computation, then coefficient write while busy is ignored
      wr_coef(0, 12'd1);
      send(12'h055);
      repeat (5) @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         if (valid) nvalid++;
      end
      check("abort_no_valid", nvalid, 0);
      check("abort_yout", yout, 0);
      wr_coef(0, 12'd1);
      wr_coef(1, 12'd2);
      send(12'd3);
      coef_we = 1'b1; coef_addr = 4'd2; coef_data = 12'd100;
      @(negedge clk);
      coef_we = 1'b0;
      wait_valid("busywr0", lat, y);
      check("cleared_delay", y, 3);
      send(12'd0);
      wait_valid("busywr1", lat, y);
      check("impulse_h1", y, 6);
      send(12'd0);
      wait_valid("busywr2", lat, y);
      check("busy_write_ignored", y, 0);

      // Randomized traffic with occasional reset
      do_reset();
      for (int k = 0; k < TAPS; k++) wr_coef(k, 12'($urandom));
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rstn      = (c != 2000);
         en        = ($urandom_range(0, 11) == 0);
         xin       = 12'($urandom);
         coef_we   = ($urandom_range(0, 5) == 0);
         coef_addr = 4'($urandom);
         coef_data = 12'($urandom);
         ovr_clr   = ($urandom_range(0, 23) == 0);
      end
      @(negedge clk);
      rstn = 1'b1; en = 1'b0; coef_we = 1'b0; ovr_clr = 1'b0;
      repeat (LAT + 4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
